// File: rtl/stage2_mult_seq_if.sv
// rtl/stage2_mult_seq_if.sv - window/kernel/tap bundle for stage2_mult_seq (win_mask only with STAGE2_BORDER_EN)
interface stage2_mult_seq_if #(
   parameter int PIX_W  = 8,
   parameter int COEF_W = 5
);
   localparam int PROD_W = PIX_W + COEF_W + 1;

   logic                     win_valid;
   logic                     win_ready;
   logic [9*PIX_W-1:0]       win_pix;
   logic                     kern_load;
   logic [9*COEF_W-1:0]      kern_data;
`ifdef STAGE2_BORDER_EN
   logic [8:0]               win_mask;
`endif
   logic signed [PROD_W-1:0] prod1, prod2, prod3, prod4, prod5, prod6, prod7, prod8, prod9;
   logic                     prod1_valid, prod2_valid, prod3_valid, prod4_valid, prod5_valid;
   logic                     prod6_valid, prod7_valid, prod8_valid, prod9_valid;
   logic                     stage3_start;
   logic                     win_done;

   modport master (
`ifdef STAGE2_BORDER_EN
      output win_mask,
`endif
      output win_valid, win_pix, kern_load, kern_data,
      input  win_ready,
      input  prod1, prod2, prod3, prod4, prod5, prod6, prod7, prod8, prod9,
      input  prod1_valid, prod2_valid, prod3_valid, prod4_valid, prod5_valid,
      input  prod6_valid, prod7_valid, prod8_valid, prod9_valid,
      input  stage3_start, win_done
   );

   modport slave (
`ifdef STAGE2_BORDER_EN
      input  win_mask,
`endif
      input  win_valid, win_pix, kern_load, kern_data,
      output win_ready,
      output prod1, prod2, prod3, prod4, prod5, prod6, prod7, prod8, prod9,
      output prod1_valid, prod2_valid, prod3_valid, prod4_valid, prod5_valid,
      output prod6_valid, prod7_valid, prod8_valid, prod9_valid,
      output stage3_start, win_done
   );
endinterface

// File: rtl/stage2_mult_seq.sv
// rtl/stage2_mult_seq.sv - serial 3x3 pixel x kernel multiply sequencer; STAGE2_BORDER_EN adds win_mask zero-padding
module stage2_mult_seq #(
   parameter int PIX_W      = 8,
   parameter int COEF_W     = 5,
   parameter int GAP_CYCLES = 2
) (
   input  logic             clk,
   input  logic             rst,
   stage2_mult_seq_if.slave bus
);
   localparam int PROD_W = PIX_W + COEF_W + 1;

   // DONE and GAP together hold off the next accept for GAP_CYCLES cycles after tap 9;
   // the last of those cycles is spent in IDLE so an accept can land on edge 10+GAP_CYCLES.
   localparam logic [3:0] GAP_LOAD = (GAP_CYCLES >= 2) ? 4'(GAP_CYCLES - 2) : 4'd0;

   typedef enum logic [1:0] {IDLE, RUN, DONE, GAP} state_t;

   state_t                   state;
   logic [3:0]               tap_idx;
   logic [3:0]               gap_cnt;
   logic [PIX_W-1:0]         pix_q  [9];
   logic signed [COEF_W-1:0] coef_q [9];
   logic signed [PROD_W-1:0] prod_q [9];
   logic [8:0]               valid_q;
   logic                     done_pend;
   logic                     win_done_q;
   logic                     start_q;
   logic                     accept;
   logic signed [PROD_W-1:0] tap_prod;
`ifdef STAGE2_BORDER_EN
   logic [8:0]               mask_q;
`endif

   function automatic logic signed [PROD_W-1:0] mul_tap(input logic [PIX_W-1:0] p,
                                                       input logic signed [COEF_W-1:0] c);
      logic signed [PROD_W-1:0] p_ext;
      logic signed [PROD_W-1:0] c_ext;
      p_ext = signed'({{(PROD_W-PIX_W){1'b0}}, p});
      c_ext = {{(PROD_W-COEF_W){c[COEF_W-1]}}, c};
      return p_ext * c_ext;
   endfunction

   assign accept        = bus.win_valid && (state == IDLE);
   assign bus.win_ready = (state == IDLE);

   // product for the tap currently being issued, zeroed at masked border positions
   always_comb begin
      tap_prod = mul_tap(pix_q[tap_idx], coef_q[tap_idx]);
`ifdef STAGE2_BORDER_EN
      if (mask_q[tap_idx]) tap_prod = '0;
`endif
   end

   // sequencer: window capture, one tap per cycle, done pulse and inter-window gap
   always_ff @(posedge clk) begin
      if (!rst) begin
         state      <= IDLE;
         tap_idx    <= 4'd0;
         gap_cnt    <= 4'd0;
         valid_q    <= 9'd0;
         done_pend  <= 1'b0;
         win_done_q <= 1'b0;
         start_q    <= 1'b0;
         for (int i = 0; i < 9; i++) begin
            pix_q[i]  <= '0;
            coef_q[i] <= '0;
            prod_q[i] <= '0;
         end
`ifdef STAGE2_BORDER_EN
         mask_q     <= 9'd0;
`endif
      end else begin
         valid_q    <= 9'd0;
         done_pend  <= 1'b0;
         win_done_q <= done_pend;

         // kernel writes only while idle; a same-cycle accept sees the new kernel from tap 1
         if (state == IDLE && bus.kern_load) begin
            for (int i = 0; i < 9; i++) coef_q[i] <= bus.kern_data[i*COEF_W +: COEF_W];
         end

         case (state)
            IDLE: ;
            RUN: begin
               prod_q[tap_idx]  <= tap_prod;
               valid_q[tap_idx] <= 1'b1;
               tap_idx          <= tap_idx + 4'd1;
               if (tap_idx == 4'd8) begin
                  done_pend <= 1'b1;
                  state     <= (GAP_CYCLES == 0) ? IDLE : DONE;
               end
            end
            DONE: begin
               if (GAP_CYCLES <= 1) begin
                  state <= IDLE;
               end else begin
                  state   <= GAP;
                  gap_cnt <= GAP_LOAD;
               end
            end
            GAP: begin
               if (gap_cnt == 4'd0) state <= IDLE;
               else                 gap_cnt <= gap_cnt - 4'd1;
            end
            default: state <= IDLE;
         endcase

         if (accept) begin
            state   <= RUN;
            tap_idx <= 4'd0;
            start_q <= 1'b1;
            for (int i = 0; i < 9; i++) pix_q[i] <= bus.win_pix[i*PIX_W +: PIX_W];
`ifdef STAGE2_BORDER_EN
            mask_q  <= bus.win_mask;
`endif
         end else if (done_pend) begin
            start_q <= 1'b0;
         end
      end
   end

   assign bus.prod1        = prod_q[0];
   assign bus.prod2        = prod_q[1];
   assign bus.prod3        = prod_q[2];
   assign bus.prod4        = prod_q[3];
   assign bus.prod5        = prod_q[4];
   assign bus.prod6        = prod_q[5];
   assign bus.prod7        = prod_q[6];
   assign bus.prod8        = prod_q[7];
   assign bus.prod9        = prod_q[8];
   assign bus.prod1_valid  = valid_q[0];
   assign bus.prod2_valid  = valid_q[1];
   assign bus.prod3_valid  = valid_q[2];
   assign bus.prod4_valid  = valid_q[3];
   assign bus.prod5_valid  = valid_q[4];
   assign bus.prod6_valid  = valid_q[5];
   assign bus.prod7_valid  = valid_q[6];
   assign bus.prod8_valid  = valid_q[7];
   assign bus.prod9_valid  = valid_q[8];
   assign bus.stage3_start = start_q;
   assign bus.win_done     = win_done_q;
endmodule

// File: tb/tb_stage2_mult_seq.sv
// tb/tb_stage2_mult_seq.sv - randomized self-checking bench for stage2_mult_seq
module tb_stage2_mult_seq;
   localparam int PIX_W  = 8;
   localparam int COEF_W = 5;
   localparam int GAP    = 2;
   localparam int PROD_W = PIX_W + COEF_W + 1;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   stage2_mult_seq_if #(.PIX_W(PIX_W), .COEF_W(COEF_W)) bus ();

   stage2_mult_seq #(.PIX_W(PIX_W), .COEF_W(COEF_W), .GAP_CYCLES(GAP)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   int wcount   = 0;
   int last_acc = -1;
   int prev_acc = -1;
   int kern_m   [9];
   int exp_prod [9];
   int pix_a    [9];
   int pix_b    [9];
   int k_a      [9];
   int k_two    [9];
   logic [PROD_W-1:0] raw;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_eq(input string tag, input longint got, input longint exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   function automatic int get_prod(input int i);
      case (i)
         0: return int'(bus.prod1);
         1: return int'(bus.prod2);
         2: return int'(bus.prod3);
         3: return int'(bus.prod4);
         4: return int'(bus.prod5);
         5: return int'(bus.prod6);
         6: return int'(bus.prod7);
         7: return int'(bus.prod8);
         8: return int'(bus.prod9);
         default: return 0;
      endcase
   endfunction

   function automatic logic [8:0] get_valids();
      return {bus.prod9_valid, bus.prod8_valid, bus.prod7_valid, bus.prod6_valid, bus.prod5_valid,
              bus.prod4_valid, bus.prod3_valid, bus.prod2_valid, bus.prod1_valid};
   endfunction

   function automatic logic [9*PIX_W-1:0] pack_pix(input int p[9]);
      logic [9*PIX_W-1:0] v;
      for (int i = 0; i < 9; i++) v[i*PIX_W +: PIX_W] = PIX_W'(p[i]);
      return v;
   endfunction

   function automatic logic [9*COEF_W-1:0] pack_kern(input int k[9]);
      logic [9*COEF_W-1:0] v;
      for (int i = 0; i < 9; i++) v[i*COEF_W +: COEF_W] = COEF_W'(k[i]);
      return v;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_outputs(input string tag, input logic [8:0] exp_v, input bit exp_start,
                                input bit exp_done, input bit exp_ready);
      check_eq({tag, ".valid"}, get_valids(), exp_v);
      check_eq({tag, ".start"}, bus.stage3_start, exp_start);
      check_eq({tag, ".done"}, bus.win_done, exp_done);
      check_eq({tag, ".ready"}, bus.win_ready, exp_ready);
      for (int i = 0; i < 9; i++)
         check_eq($sformatf("%s.prod%0d", tag, i + 1), get_prod(i), exp_prod[i]);
   endtask

   task automatic load_kernel(input int k[9]);
      check_eq("kload.ready", bus.win_ready, 1);
      bus.kern_data = pack_kern(k);
      bus.kern_load = 1'b1;
      step();
      bus.kern_load = 1'b0;
      kern_m = k;
   endtask

   task automatic randomize_window(output int p[9], output int k[9]);
      for (int i = 0; i < 9; i++) begin
         p[i] = int'($urandom_range(0, 255));
         k[i] = int'($urandom_range(0, 31)) - 16;
      end
   endtask

   task automatic run_window(input int pix[9], input logic [8:0] mask, input bit hold,
                             input bit with_load, input int newk[9], input bit bad_load,
                             input int rst_at);
      int guard;
      logic [8:0] eff_mask;
      logic [8:0] seen;
      int two[9];
      wcount++;
`ifdef STAGE2_BORDER_EN
      eff_mask     = mask;
      bus.win_mask = mask;
`else
      eff_mask     = 9'd0;
`endif
      bus.win_pix   = pack_pix(pix);
      bus.win_valid = 1'b1;
      if (with_load) begin
         bus.kern_data = pack_kern(newk);
         bus.kern_load = 1'b1;
      end
      guard = 0;
      while (!bus.win_ready && guard < 50) begin
         step();
         guard++;
      end
      if (guard >= 50) begin
         check_eq("accept_timeout", guard, 0);
         bus.win_valid = 1'b0;
         bus.kern_load = 1'b0;
         return;
      end
      @(posedge clk);
      if (with_load) kern_m = newk;
      #1;
      prev_acc      = last_acc;
      last_acc      = cyc;
      bus.kern_load = 1'b0;
      if (!hold) bus.win_valid = 1'b0;
      for (int c = 0; c <= 11; c++) begin
         if (c > 0) step();
         if (c >= 1 && c <= 9)
            exp_prod[c-1] = eff_mask[c-1] ? 0 : pix[c-1] * kern_m[c-1];
         check_outputs($sformatf("w%0d.c%0d", wcount, c),
                       (c >= 1 && c <= 9) ? 9'(1 << (c - 1)) : 9'd0,
                       c <= 9, c == 10, c >= 9 + GAP);
         if (bad_load && c == 3) begin
            for (int i = 0; i < 9; i++) two[i] = 2;
            bus.kern_data = pack_kern(two);
            bus.kern_load = 1'b1;
         end
         if (bad_load && c == 4) bus.kern_load = 1'b0;
         if (rst_at != 0 && c == rst_at) begin
            rst = 1'b0;
            step();
            for (int i = 0; i < 9; i++) begin
               kern_m[i]   = 0;
               exp_prod[i] = 0;
            end
            check_outputs($sformatf("w%0d.rst", wcount), 9'd0, 1'b0, 1'b0, 1'b1);
            rst           = 1'b1;
            bus.win_valid = 1'b0;
            seen          = 9'd0;
            for (int j = 0; j < 12; j++) begin
               step();
               seen = seen | get_valids();
            end
            check_eq("rst.no_strobes", seen, 0);
            check_outputs($sformatf("w%0d.post_rst", wcount), 9'd0, 1'b0, 1'b0, 1'b1);
            return;
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      bus.win_valid = 1'b0;
      bus.win_pix   = '0;
      bus.kern_load = 1'b0;
      bus.kern_data = '0;
`ifdef STAGE2_BORDER_EN
      bus.win_mask  = 9'd0;
`endif
      for (int i = 0; i < 9; i++) begin
         kern_m[i]   = 0;
         exp_prod[i] = 0;
         k_two[i]    = 2;
      end

      rst = 1'b0;
      repeat (3) step();
      check_outputs("reset", 9'd0, 1'b0, 1'b0, 1'b1);
      rst = 1'b1;
      step();
      check_eq("ready_after_release", bus.win_ready, 1);

      // ramp: kernel all +1, pixels 10..90
      for (int i = 0; i < 9; i++) begin
         k_a[i]   = 1;
         pix_a[i] = 10 * (i + 1);
      end
      load_kernel(k_a);
      run_window(pix_a, 9'd0, 1'b0, 1'b0, k_a, 1'b0, 0);

      // extremes on taps 1 and 2
      randomize_window(pix_a, k_a);
      k_a[0]   = -16;
      k_a[1]   = 15;
      pix_a[0] = 255;
      pix_a[1] = 255;
      load_kernel(k_a);
      run_window(pix_a, 9'd0, 1'b0, 1'b0, k_a, 1'b0, 0);
      raw = bus.prod1;
      check_eq("ext.prod1_raw", raw, 14'h3010);
      check_eq("ext.prod2", get_prod(1), 3825);

      // random windows, alternating kernel load with the accept
      for (int t = 0; t < 6; t++) begin
         randomize_window(pix_a, k_a);
         run_window(pix_a, 9'd0, 1'b0, t[0], k_a, 1'b0, 0);
      end

      // kernel load during RUN is ignored; the following window also keeps the old kernel
      randomize_window(pix_a, k_a);
      run_window(pix_a, 9'd0, 1'b0, 1'b0, k_a, 1'b1, 0);
      randomize_window(pix_a, k_a);
      run_window(pix_a, 9'd0, 1'b0, 1'b0, k_a, 1'b0, 0);

      // kernel load in the accept cycle applies to that window
      randomize_window(pix_a, k_a);
      run_window(pix_a, 9'd0, 1'b0, 1'b1, k_two, 1'b0, 0);

      // back-to-back with win_valid held high
      randomize_window(pix_a, k_a);
      randomize_window(pix_b, k_a);
      run_window(pix_a, 9'd0, 1'b1, 1'b0, k_a, 1'b0, 0);
      run_window(pix_b, 9'd0, 1'b0, 1'b0, k_a, 1'b0, 0);
      check_eq("b2b.spacing", last_acc - prev_acc, 10 + GAP);

      // reset after E4 of a window
      randomize_window(pix_a, k_a);
      load_kernel(k_a);
      run_window(pix_a, 9'd0, 1'b0, 1'b0, k_a, 1'b0, 4);

      // kernel is zero after reset until reloaded
      randomize_window(pix_a, k_a);
      run_window(pix_a, 9'd0, 1'b0, 1'b0, k_a, 1'b0, 0);
      run_window(pix_a, 9'd0, 1'b0, 1'b1, k_a, 1'b0, 0);

`ifdef STAGE2_BORDER_EN
      for (int i = 0; i < 9; i++) begin
         k_a[i]   = 1;
         pix_a[i] = 10 * (i + 1);
      end
      load_kernel(k_a);
      run_window(pix_a, 9'b000000101, 1'b0, 1'b0, k_a, 1'b0, 0);
      check_eq("mask.prod1", get_prod(0), 0);
      check_eq("mask.prod3", get_prod(2), 0);
      check_eq("mask.prod2", get_prod(1), 20);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
